// File: rtl/tau_spi_tx.sv
// tau_spi_tx: SPI mode-0 master for one lane. Shifts 32-bit words out MSB first,
// captures the returning MISO word, and can chain words inside one CS_n frame.
module tau_spi_tx #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned GAP     = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] tx_data,
    input  logic        tx_last,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [31:0] rx_data,
    output logic        rx_valid,
    output logic        busy,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO,
    output logic        CS_n
);

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned BIT_W   = 6;
    localparam int unsigned HP_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned GAP_W   = (GAP > 1) ? $clog2(GAP) : 1;
    // Half-period index of the 32nd high phase; its falling edge ends SHIFT.
    localparam int unsigned LAST_HP = 2 * WORD_W - 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_WAITN,
        S_GAP
    } state_e;

    state_e            state_q, state_d;
    logic [HP_W-1:0]   hp_q, hp_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [WORD_W-1:0] sh_q, sh_d;
    logic [WORD_W-1:0] cap_q, cap_d;
    logic [WORD_W-1:0] rx_data_q, rx_data_d;
    logic              last_q, last_d;
    logic              sclk_q, sclk_d;
    logic              csn_q, csn_d;
    logic              rx_valid_q, rx_valid_d;
    logic              busy_q, busy_d;
    logic              miso_s1_q, miso_s1_d;
    logic              miso_s2_q, miso_s2_d;
    logic              tick;
    logic [HP_W-1:0]   hp_next;

    // Word acceptance depends on state only, never on tx_valid.
    assign tx_ready = (state_q == S_IDLE) || (state_q == S_WAITN);

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;
    assign SCLK     = sclk_q;
    assign MOSI     = sh_q[WORD_W-1];
    assign CS_n     = csn_q;

    // Half-period timebase shared by SETUP, SHIFT, HOLD and GAP.
    always_comb begin
        tick    = (hp_q == HP_W'(CLK_DIV - 1));
        hp_next = tick ? '0 : hp_q + HP_W'(1);
    end

    // MISO is asynchronous; two flops before it reaches the capture register.
    always_comb begin
        miso_s1_d = MISO;
        miso_s2_d = miso_s1_q;
    end

    always_comb begin
        state_d    = state_q;
        hp_d       = hp_q;
        bit_d      = bit_q;
        gap_d      = gap_q;
        sh_d       = sh_q;
        cap_d      = cap_q;
        rx_data_d  = rx_data_q;
        last_d     = last_q;
        sclk_d     = sclk_q;
        csn_d      = csn_q;
        rx_valid_d = 1'b0;

        unique case (state_q)
            S_IDLE, S_WAITN: begin
                hp_d = '0;
                if (tx_valid) begin
                    sh_d    = tx_data;
                    last_d  = tx_last;
                    csn_d   = 1'b0;
                    bit_d   = '0;
                    state_d = S_SETUP;
                end
            end

            S_SETUP: begin
                hp_d = hp_next;
                if (tick) begin
                    sclk_d  = 1'b1;
                    state_d = S_SHIFT;
                end
            end

            S_SHIFT: begin
                hp_d = hp_next;
                if (tick) begin
                    sclk_d = ~sclk_q;
                    bit_d  = bit_q + BIT_W'(1);
                    if (sclk_q) begin
                        cap_d = {cap_q[WORD_W-2:0], miso_s2_q};
                        if (bit_q == BIT_W'(LAST_HP)) begin
                            bit_d   = '0;
                            state_d = S_HOLD;
                        end else begin
                            sh_d = {sh_q[WORD_W-2:0], 1'b0};
                        end
                    end
                end
            end

            S_HOLD: begin
                hp_d = hp_next;
                if (tick) begin
                    rx_data_d  = cap_q;
                    rx_valid_d = 1'b1;
                    if (last_q) begin
                        csn_d   = 1'b1;
                        gap_d   = '0;
                        state_d = S_GAP;
                    end else begin
                        state_d = S_WAITN;
                    end
                end
            end

            S_GAP: begin
                hp_d = hp_next;
                if (tick) begin
                    if (gap_q == GAP_W'(GAP - 1)) begin
                        gap_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            hp_q       <= '0;
            bit_q      <= '0;
            gap_q      <= '0;
            sh_q       <= '0;
            cap_q      <= '0;
            rx_data_q  <= '0;
            last_q     <= 1'b0;
            sclk_q     <= 1'b0;
            csn_q      <= 1'b1;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            miso_s1_q  <= 1'b0;
            miso_s2_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hp_q       <= hp_d;
            bit_q      <= bit_d;
            gap_q      <= gap_d;
            sh_q       <= sh_d;
            cap_q      <= cap_d;
            rx_data_q  <= rx_data_d;
            last_q     <= last_d;
            sclk_q     <= sclk_d;
            csn_q      <= csn_d;
            rx_valid_q <= rx_valid_d;
            busy_q     <= busy_d;
            miso_s1_q  <= miso_s1_d;
            miso_s2_q  <= miso_s2_d;
        end
    end

endmodule

// File: tb/tb_tau_spi_tx.sv
// Bench for tau_spi_tx: directed frame sequences with random payloads, checked
// cycle by cycle against an arithmetic model of the SPI frame timing.
module tb_tau_spi_tx;

    localparam int D     = 4;
    localparam int G     = 2;
    localparam int D7    = 7;
    localparam int FRAME = 65 * D;
    localparam int GD    = G * D;

    typedef struct packed {
        logic [31:0] w;
        logic        last;
        logic [31:0] s;
    } word_t;

    logic        clk;
    logic        rstn;
    logic [31:0] tx_data;
    logic        tx_last;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        busy;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
    logic        CS_n;

    logic [31:0] tx_data7;
    logic        tx_last7;
    logic        tx_valid7;
    logic        tx_ready7;
    logic [31:0] rx_data7;
    logic        rx_valid7;
    logic        busy7;
    logic        sclk7;
    logic        mosi7;
    logic        miso7;
    logic        csn7;

    tau_spi_tx #(.CLK_DIV(D), .GAP(G)) dut (
        .clk(clk), .rstn(rstn), .tx_data(tx_data), .tx_last(tx_last),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
        .rx_valid(rx_valid), .busy(busy), .SCLK(SCLK), .MOSI(MOSI),
        .MISO(MISO), .CS_n(CS_n)
    );

    tau_spi_tx #(.CLK_DIV(D7), .GAP(G)) dut7 (
        .clk(clk), .rstn(rstn), .tx_data(tx_data7), .tx_last(tx_last7),
        .tx_valid(tx_valid7), .tx_ready(tx_ready7), .rx_data(rx_data7),
        .rx_valid(rx_valid7), .busy(busy7), .SCLK(sclk7), .MOSI(mosi7),
        .MISO(miso7), .CS_n(csn7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total;
    int          bad;
    int          cyc;
    logic [31:0] exp_rx;
    word_t       wq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_sclk"},     32'(SCLK),     32'd0);
        chk({tag, "_mosi"},     32'(MOSI),     32'd0);
        chk({tag, "_csn"},      32'(CS_n),     32'd1);
        chk({tag, "_tx_ready"}, 32'(tx_ready), 32'd1);
        chk({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
        chk({tag, "_rx_data"},  rx_data,       32'd0);
        chk({tag, "_busy"},     32'(busy),     32'd0);
    endtask

    // Sends every word in wq with tx_valid held high; slave_mode selects a bench
    // slave driving wq[i].s (with 0-1 cycle skew) instead of MISO looped to MOSI.
    task automatic run_frames(input bit slave_mode);
        int   acc[$];
        int   gaps[$];
        int   n, endc, f, r, falls, idx, s_f, s_b, m_f, m_b, r_f;
        int   rises, rxcnt, csn_rises, nlast, gap_run;
        logic [31:0] mcap;
        logic e_sclk, e_mosi, e_csn, e_ready, e_busy, e_rxv;
        logic hs, sclk_p, csn_p, pend, pend_v, val;

        n = wq.size();
        nlast = 0;
        acc.push_back(0);
        for (int i = 0; i < n; i++) begin
            if (wq[i].last) nlast++;
            if (i < n - 1) acc.push_back(acc[i] + FRAME + 1 + (wq[i].last ? GD : 0));
        end
        endc = acc[n-1] + FRAME + GD + 1;

        idx = 0; s_f = 0; s_b = 0; m_f = 0; m_b = 0; r_f = 0;
        rises = 0; rxcnt = 0; csn_rises = 0; gap_run = 0;
        mcap = '0; pend = 1'b0; pend_v = 1'b0;
        tx_valid = 1'b1;
        tx_data  = wq[0].w;
        tx_last  = wq[0].last;
        MISO     = slave_mode ? wq[0].s[31] : MOSI;
        sclk_p   = SCLK;
        csn_p    = CS_n;

        for (int t = 1; t <= endc; t++) begin
            hs = tx_valid && tx_ready;
            step();
            if (hs) begin
                idx++;
                if (idx < n) begin
                    tx_data = wq[idx].w;
                    tx_last = wq[idx].last;
                end else begin
                    tx_valid = 1'b0;
                end
            end
            if (!tx_valid) begin
                tx_data = $urandom;
                tx_last = 1'($urandom_range(0, 1));
            end

            if (!slave_mode) begin
                MISO = MOSI;
            end else begin
                if (pend) begin
                    MISO = pend_v;
                    pend = 1'b0;
                end
                if (sclk_p && !SCLK) begin
                    s_b++;
                    if (s_b == 32) begin
                        s_b = 0;
                        s_f++;
                    end
                    val = (s_f < n) ? wq[s_f].s[31-s_b] : 1'b0;
                    if ($urandom_range(0, 1) == 0) MISO = val;
                    else begin
                        pend   = 1'b1;
                        pend_v = val;
                    end
                end
            end

            if (!sclk_p && SCLK) begin
                rises++;
                mcap = {mcap[30:0], MOSI};
                m_b++;
                if (m_b == 32) begin
                    if (m_f < n) chk("mosi_word", mcap, wq[m_f].w);
                    m_f++;
                    m_b = 0;
                end
            end
            if (rx_valid) begin
                rxcnt++;
                if (r_f < n) chk("rx_word", rx_data, slave_mode ? wq[r_f].s : wq[r_f].w);
                r_f++;
            end
            if (!csn_p && CS_n) csn_rises++;
            if (CS_n && !tx_ready) gap_run++;
            else if (gap_run > 0) begin
                gaps.push_back(gap_run);
                gap_run = 0;
            end

            // Frame model: locate the word whose accept precedes this cycle.
            f = 0;
            for (int i = 0; i < n; i++) if (acc[i] < t) f = i;
            r = t - acc[f];
            if (r <= FRAME) begin
                e_csn   = 1'b0;
                e_ready = 1'b0;
                e_busy  = 1'b1;
                e_rxv   = 1'b0;
                e_sclk  = (r >= D + 1) && ((((r - (D + 1)) / D) % 2) == 0);
                falls   = (r >= 2 * D + 1) ? (r - (2 * D + 1)) / (2 * D) + 1 : 0;
                if (falls > 31) falls = 31;
                e_mosi  = wq[f].w[31-falls];
            end else begin
                e_sclk = 1'b0;
                e_mosi = wq[f].w[0];
                e_rxv  = (r == FRAME + 1);
                if (wq[f].last) begin
                    e_csn   = 1'b1;
                    e_ready = (r > FRAME + GD);
                    e_busy  = !e_ready;
                end else begin
                    e_csn   = 1'b0;
                    e_ready = 1'b1;
                    e_busy  = 1'b1;
                end
            end
            if (e_rxv) exp_rx = slave_mode ? wq[f].s : wq[f].w;

            chk("csn",      32'(CS_n),     32'(e_csn));
            chk("sclk",     32'(SCLK),     32'(e_sclk));
            chk("mosi",     32'(MOSI),     32'(e_mosi));
            chk("tx_ready", 32'(tx_ready), 32'(e_ready));
            chk("busy",     32'(busy),     32'(e_busy));
            chk("rx_valid", 32'(rx_valid), 32'(e_rxv));
            chk("rx_data",  rx_data,       exp_rx);

            sclk_p = SCLK;
            csn_p  = CS_n;
        end

        chk("rise_count", 32'(rises),       32'(32 * n));
        chk("rx_pulses",  32'(rxcnt),       32'(n));
        chk("csn_rises",  32'(csn_rises),   32'(nlast));
        chk("gap_count",  32'(gaps.size()), 32'(nlast));
        foreach (gaps[i]) chk("gap_len", 32'(gaps[i]), 32'(GD));
    endtask

    // Single word on the CLK_DIV = 7 lane with MISO looped to MOSI.
    task automatic run_d7(input logic [31:0] w);
        int   hi[$];
        int   lo[$];
        int   csn_low, rises, len, rxc;
        logic sp, seen;
        logic [31:0] mc;

        csn_low = 0; rises = 0; len = 0; rxc = 0; seen = 1'b0; mc = '0;
        tx_data7  = w;
        tx_last7  = 1'b1;
        tx_valid7 = 1'b1;
        sp = sclk7;
        step();
        tx_valid7 = 1'b0;
        for (int t = 1; t <= 65 * D7 + G * D7 + 2; t++) begin
            if (t > 1) step();
            miso7 = mosi7;
            if (!csn7) csn_low++;
            if (sclk7 == sp) len++;
            else begin
                if (sp) hi.push_back(len);
                else if (seen) lo.push_back(len);
                len = 1;
            end
            if (!sp && sclk7) begin
                seen = 1'b1;
                rises++;
                mc = {mc[30:0], mosi7};
            end
            if (rx_valid7) begin
                rxc++;
                chk("d7_rx_data", rx_data7, w);
            end
            sp = sclk7;
        end
        chk("d7_csn_low",  32'(csn_low),   32'd455);
        chk("d7_rises",    32'(rises),     32'd32);
        chk("d7_mosi",     mc,             w);
        chk("d7_rx_count", 32'(rxc),       32'd1);
        chk("d7_hi_count", 32'(hi.size()), 32'd32);
        chk("d7_lo_count", 32'(lo.size()), 32'd31);
        foreach (hi[i]) chk("d7_hi_len", 32'(hi[i]), 32'(D7));
        foreach (lo[i]) chk("d7_lo_len", 32'(lo[i]), 32'(D7));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d observed=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; bad = 0; cyc = 0; exp_rx = '0;
        rstn = 1'b0;
        tx_valid = 1'b0; tx_data = '0; tx_last = 1'b0; MISO = 1'b0;
        tx_valid7 = 1'b0; tx_data7 = '0; tx_last7 = 1'b0; miso7 = 1'b0;

        repeat (3) step();
        chk_reset("por");
        rstn = 1'b1;
        repeat (2) step();
        chk_reset("idle");

        // Single word, loopback.
        wq.delete();
        wq.push_back('{w: 32'hA5C3_0F81, last: 1'b1, s: 32'h0});
        run_frames(1'b0);

        // Two chained words in one CS_n frame.
        wq.delete();
        wq.push_back('{w: 32'h0000_0001, last: 1'b0, s: 32'h0});
        wq.push_back('{w: 32'hFFFF_FFFF, last: 1'b1, s: 32'h0});
        run_frames(1'b0);

        // Slave returns a fixed word with skewed MISO updates.
        wq.delete();
        wq.push_back('{w: $urandom, last: 1'b1, s: 32'h1234_5678});
        run_frames(1'b1);

        // Back-to-back frames separated by the minimum gap.
        wq.delete();
        for (int i = 0; i < 3; i++) wq.push_back('{w: $urandom, last: 1'b1, s: $urandom});
        run_frames(1'b1);

        // Random mix of chained and separate words.
        wq.delete();
        for (int i = 0; i < 5; i++)
            wq.push_back('{w: $urandom, last: 1'($urandom_range(0, 1)), s: $urandom});
        wq.push_back('{w: $urandom, last: 1'b1, s: $urandom});
        run_frames(1'b1);

        // Reset in the middle of a word.
        tx_valid = 1'b1;
        tx_data  = $urandom;
        tx_last  = 1'b1;
        step();
        tx_valid = 1'b0;
        repeat (99) step();
        chk("midword_busy", 32'(busy), 32'd1);
        rstn = 1'b0;
        #1;
        chk_reset("rst_async");
        repeat (4) begin
            step();
            chk("rst_no_rx_valid", 32'(rx_valid), 32'd0);
        end
        rstn = 1'b1;
        repeat (2) step();
        chk_reset("rst_release");
        exp_rx = '0;
        wq.delete();
        wq.push_back('{w: $urandom, last: 1'b1, s: $urandom});
        run_frames(1'b1);

        run_d7($urandom);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
